// File: rtl/ucsbece154a_muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 encodings and the
// iterative unit's state encoding.
package ucsbece154a_defines;

   localparam logic [2:0] MULDIV_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_REM    = 3'b110;
   localparam logic [2:0] MULDIV_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // funct3[2] separates the divide family from the multiply family
   function automatic logic md_is_div(input logic [2:0] f);
      return f[2];
   endfunction

endpackage

// File: rtl/ucsbece154a_muldiv_if.sv
// Request/response bundle between the decode/RF stage and the muldiv unit.
// The unit side is the slave; the issuing pipeline is the master.
interface ucsbece154a_muldiv_if;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [4:0]  rd_i;
   logic        kill_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   modport slave (
      input  start_i, funct3_i, a_i, b_i, rd_i, kill_i,
      output busy_o, done_o, result_o, rd_o
   );

   modport master (
      output start_i, funct3_i, a_i, b_i, rd_i, kill_i,
      input  busy_o, done_o, result_o, rd_o
   );
endinterface

// File: rtl/ucsbece154a_muldiv.sv
// Iterative RV32M mul/div: 32 radix-2 steps on operand magnitudes, sign fix-up on exit.
// Accept at E0 -> busy cycles 1..32, one-cycle done in 33; pipeline stalls on busy_o.
module ucsbece154a_muldiv
   import ucsbece154a_defines::*;
#(
   parameter int XLEN = 32
) (
   input  logic               clk,
   input  logic               reset,
   ucsbece154a_muldiv_if.slave md
);

   md_state_e        state_q;
   logic [4:0]       cnt_q;
   logic [2:0]       f_q;
   logic [4:0]       rd_q;
   logic             neg_q;
   logic             a_neg_q;
   logic             bz_q;
   logic [XLEN-1:0]  hi_q, lo_q, b_q;
   logic [XLEN-1:0]  result_q;
   logic [4:0]       rd_out_q;
   logic             busy_q, done_q;

   logic             accept;
   logic             a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]  a_mag, b_mag;

   assign accept = md.start_i && (state_q != MD_RUN);

   always_comb begin
      a_sgn = (md.funct3_i != MULDIV_MULHU) && (md.funct3_i != MULDIV_DIVU) &&
              (md.funct3_i != MULDIV_REMU);
      b_sgn = a_sgn && (md.funct3_i != MULDIV_MULHSU);
      a_neg = a_sgn && md.a_i[XLEN-1];
      b_neg = b_sgn && md.b_i[XLEN-1];
      // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned
      a_mag = a_neg ? -md.a_i : md.a_i;
      b_mag = b_neg ? -md.b_i : md.b_i;
   end

   // One iteration: multiply shifts {hi,lo} right, divide shifts it left
   logic [XLEN:0]    mul_sum;
   logic [XLEN:0]    div_sh;
   logic             div_ok;
   logic [XLEN-1:0]  div_sub;
   logic [XLEN-1:0]  step_hi, step_lo;

   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_sh  = {hi_q, lo_q[XLEN-1]};
      div_ok  = div_sh >= {1'b0, b_q};
      div_sub = div_sh[XLEN-1:0] - b_q;
      if (md_is_div(f_q)) begin
         step_hi = div_ok ? div_sub : div_sh[XLEN-1:0];
         step_lo = {lo_q[XLEN-2:0], div_ok};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, result_d;

   always_comb begin
      prod_s   = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
      quo_s    = neg_q ? -step_lo : step_lo;
      rem_s    = a_neg_q ? -step_hi : step_hi;
      result_d = '0;
      unique case (f_q)
         MULDIV_MUL:                             result_d = prod_s[XLEN-1:0];
         MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
         // signed divide by zero would otherwise pick up the dividend's sign
         MULDIV_DIV, MULDIV_DIVU:                result_d = bz_q ? '1 : quo_s;
         MULDIV_REM, MULDIV_REMU:                result_d = rem_s;
         default:                                result_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         f_q      <= '0;
         rd_q     <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         bz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         result_q <= '0;
         rd_out_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            MD_IDLE, MD_DONE: begin
               done_q <= 1'b0;
               if (accept) begin
                  state_q <= MD_RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= 5'd31;
                  f_q     <= md.funct3_i;
                  rd_q    <= md.rd_i;
                  neg_q   <= a_neg ^ b_neg;
                  a_neg_q <= a_neg;
                  bz_q    <= (md.b_i == '0);
                  hi_q    <= '0;
                  lo_q    <= a_mag;
                  b_q     <= b_mag;
               end else begin
                  state_q <= MD_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            MD_RUN: begin
               if (md.kill_i) begin
                  state_q <= MD_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  hi_q  <= step_hi;
                  lo_q  <= step_lo;
                  cnt_q <= cnt_q - 5'd1;
                  if (cnt_q == 5'd0) begin
                     state_q  <= MD_DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= result_d;
                     rd_out_q <= rd_q;
                  end
               end
            end
            default: begin
               state_q <= MD_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign md.busy_o   = busy_q;
   assign md.done_o   = done_q;
   assign md.result_o = result_q;
   assign md.rd_o     = rd_out_q;

endmodule
